// File: rtl/vec3_uart_tx_pkg.sv
// Shared types and constants for the vec3 UART transmitter.
//   vec3_t         : 96-bit vec3 payload, x=[95:64], y=[63:32], z=[31:0]
//   VEC3_BYTES     : payload bytes per frame
//   FRAME_BYTES    : sync + payload + checksum
//   UART_SYNC      : default sync byte that opens every frame
//   frame_state_t  : top-level frame FSM states
//   byte_state_t   : per-byte 8N1 shifter states
//   vec3_byte()    : selects payload byte idx, most-significant byte first
package vec3_uart_tx_pkg;

  localparam int VEC3_BYTES  = 12;
  localparam int FRAME_BYTES = VEC3_BYTES + 2;
  localparam logic [7:0] UART_SYNC = 8'hA5;

  typedef logic [95:0] vec3_t;

  typedef enum logic [2:0] {
    FR_IDLE,
    FR_SEND_SYNC,
    FR_SEND_PAYLOAD,
    FR_SEND_CSUM,
    FR_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    BT_IDLE,
    BT_START,
    BT_DATA,
    BT_STOP
  } byte_state_t;

  // Byte 0 is [95:88], byte 11 is [7:0].
  function automatic logic [7:0] vec3_byte(input vec3_t v, input logic [3:0] idx);
    logic [6:0] lsb;
    lsb = 7'(8 * (VEC3_BYTES - 1 - int'(idx)));
    return v[lsb +: 8];
  endfunction

endpackage

// File: rtl/vec3_uart_tx_if.sv
// Upstream valid/ready handshake carrying one vec3 per transfer.
//   vec_in    : vec3 payload from the producer
//   valid_in  : producer has a vec3 available
//   ready_out : transmitter can accept a vec3 this cycle
// The master modport is the producer side, slave is the transmitter side.
interface vec3_uart_tx_if;
  import vec3_uart_tx_pkg::*;

  vec3_t vec_in;
  logic  valid_in;
  logic  ready_out;

  modport master (output vec_in, output valid_in, input ready_out);
  modport slave  (input vec_in, input valid_in, output ready_out);

endinterface

// File: rtl/vec3_uart_tx_byte.sv
// 8N1 byte serializer with its own baud counter.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   data_in        : byte to send, sampled when start_in is taken
//   start_in       : request to send data_in; taken in IDLE or in the last
//                    stop-bit cycle so consecutive bytes have no gap
//   busy_out       : a byte is on the line
//   done_out       : one-cycle pulse in the last stop-bit cycle
//   txd_out        : registered serial output, idles high
module uart_byte_tx
  import vec3_uart_tx_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 868
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       start_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       txd_out
);

  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);

  byte_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign busy_out = (state_q != BT_IDLE);
  assign done_out = (state_q == BT_STOP) && bit_end;
  assign txd_out  = txd_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= BT_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    case (state_q)
      BT_IDLE: begin
        txd_d = 1'b1;
        if (start_in) begin
          state_d = BT_START;
          cnt_d   = '0;
          shreg_d = data_in;
          txd_d   = 1'b0;
        end
      end
      BT_START: begin
        if (bit_end) begin
          state_d = BT_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BT_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = BT_STOP;
            txd_d   = 1'b1;
          end else begin
            // Shift so the next data bit is always at shreg_q[0].
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BT_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (start_in) begin
            // Chain straight into the next start bit, no idle gap.
            state_d = BT_START;
            shreg_d = data_in;
            txd_d   = 1'b0;
          end else begin
            state_d = BT_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = BT_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/vec3_uart_tx.sv
// Sends one vec3 per accepted handshake as a 14-byte UART frame:
// SYNC_BYTE, 12 payload bytes MSB first, XOR checksum of the payload.
//   clk_in, rst_in   : clock, asynchronous active-high reset
//   up_if (slave)    : vec_in / valid_in / ready_out handshake
//   uart_txd_out     : serial line, idles high
//   busy_out         : frame in progress
//   frames_sent_out  : completed frames, wraps at 16 bits
module vec3_uart_tx
  import vec3_uart_tx_pkg::*;
#(
  parameter int         CLK_HZ    = 100_000_000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] SYNC_BYTE = UART_SYNC
) (
  input  logic              clk_in,
  input  logic              rst_in,
  vec3_uart_tx_if.slave     up_if,
  output logic              uart_txd_out,
  output logic              busy_out,
  output logic [15:0]       frames_sent_out
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BAUD;

  frame_state_t state_q, state_d;
  vec3_t        shadow_q, shadow_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   csum_q, csum_d;
  logic [15:0]  frames_q, frames_d;

  logic         byte_start;
  logic [7:0]   byte_data;
  logic         byte_done;
  logic         byte_busy;
  logic         ready;

  assign ready           = (state_q == FR_IDLE);
  assign up_if.ready_out = ready;
  assign busy_out        = !ready || byte_busy;
  assign frames_sent_out = frames_q;

  uart_byte_tx #(
    .CYCLES_PER_BIT (CYCLES_PER_BIT)
  ) u_byte (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (byte_data),
    .start_in (byte_start),
    .busy_out (byte_busy),
    .done_out (byte_done),
    .txd_out  (uart_txd_out)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= FR_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      frames_q <= frames_d;
    end
  end

  // Each byte is issued in the same cycle the previous byte reports done,
  // so bytes run back to back. The sync byte is issued on the accepting
  // edge itself, which puts the start bit one cycle after the accept cycle
  // and leaves exactly two idle cycles (DONE + accept) between frames.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    frames_d   = frames_q;
    byte_start = 1'b0;
    byte_data  = SYNC_BYTE;
    case (state_q)
      FR_IDLE: begin
        if (up_if.valid_in) begin
          state_d    = FR_SEND_SYNC;
          shadow_d   = up_if.vec_in;
          idx_d      = '0;
          csum_d     = '0;
          byte_start = 1'b1;
          byte_data  = SYNC_BYTE;
        end
      end
      FR_SEND_SYNC: begin
        if (byte_done) begin
          state_d    = FR_SEND_PAYLOAD;
          idx_d      = '0;
          byte_start = 1'b1;
          byte_data  = vec3_byte(shadow_q, 4'd0);
          csum_d     = csum_q ^ byte_data;
        end
      end
      FR_SEND_PAYLOAD: begin
        if (byte_done) begin
          byte_start = 1'b1;
          if (idx_q == 4'(VEC3_BYTES - 1)) begin
            // csum_q already holds all twelve payload bytes.
            state_d   = FR_SEND_CSUM;
            byte_data = csum_q;
          end else begin
            idx_d     = idx_q + 4'd1;
            byte_data = vec3_byte(shadow_q, idx_q + 4'd1);
            csum_d    = csum_q ^ byte_data;
          end
        end
      end
      FR_SEND_CSUM: begin
        if (byte_done) begin
          state_d = FR_DONE;
        end
      end
      FR_DONE: begin
        frames_d = frames_q + 16'd1;
        state_d  = FR_IDLE;
      end
      default: begin
        state_d = FR_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vec3_uart_tx.sv
// Directed bench for vec3_uart_tx at 4 cycles per bit. A line monitor
// decodes every 8N1 byte from uart_txd_out and records start-bit cycles.
module tb_vec3_uart_tx;

  logic        clk_in;
  logic        rst_in;
  logic        uart_txd_out;
  logic        busy_out;
  logic [15:0] frames_sent_out;

  vec3_uart_tx_if up_if();

  vec3_uart_tx #(
    .CLK_HZ    (40),
    .BAUD      (10),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .up_if           (up_if),
    .uart_txd_out    (uart_txd_out),
    .busy_out        (busy_out),
    .frames_sent_out (frames_sent_out)
  );

  localparam logic [95:0] V1 = 96'h00010000_FFFF0000_00008000;
  localparam int CPB = 4;
  localparam int BYTE_CYC = 10 * CPB;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bad_fmt  = 0;
  logic [7:0] byte_q[$];
  int         start_q[$];

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Line monitor: samples once per cycle on the falling edge, captures
  // 40 cycles per byte and requires all 4 samples of each bit to agree.
  initial begin : monitor
    logic [39:0] bits;
    logic [7:0]  b;
    bit          aborted;
    bit          ok;
    forever begin
      @(negedge clk_in);
      if (!rst_in && uart_txd_out === 1'b0) begin
        start_q.push_back(cyc);
        bits    = '0;
        aborted = 1'b0;
        for (int k = 1; k < BYTE_CYC; k++) begin
          @(negedge clk_in);
          if (rst_in) aborted = 1'b1;
          bits[k] = uart_txd_out;
        end
        if (!aborted) begin
          ok = 1'b1;
          for (int bi = 0; bi < 10; bi++)
            for (int c = 1; c < CPB; c++)
              if (bits[bi*CPB + c] !== bits[bi*CPB]) ok = 1'b0;
          if (bits[9*CPB] !== 1'b1) ok = 1'b0;
          for (int i = 0; i < 8; i++) b[i] = bits[(i+1)*CPB];
          if (!ok) bad_fmt++;
          byte_q.push_back(b);
        end
      end
    end
  end

  task automatic send_one(input logic [95:0] v, input bit scramble, output int acc);
    int n;
    n = 0;
    while (up_if.ready_out !== 1'b1 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    chk("ready_before_send", 32'(up_if.ready_out), 32'd1);
    up_if.vec_in   = v;
    up_if.valid_in = 1'b1;
    acc = cyc;
    @(negedge clk_in);
    up_if.valid_in = 1'b0;
    if (scramble) up_if.vec_in = '1;
  endtask

  task automatic wait_idle(input string tag, output int drop);
    int n;
    n = 0;
    while (busy_out !== 1'b0 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    drop = cyc;
    chk(tag, 32'(busy_out), 32'd0);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_count"}, 32'(byte_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < byte_q.size())
        chk($sformatf("%s_b%0d", tag, i), 32'(byte_q[i]), 32'(exp[i]));
    end
    chk({tag, "_fmt"}, 32'(bad_fmt), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] exp_v1[$];
    logic [7:0] exp_zero[$];
    logic [7:0] exp_zero2[$];
    int acc, drop, n, accepts, nstarts;

    exp_v1 = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h81};
    exp_zero.push_back(8'hA5);
    for (int i = 0; i < 13; i++) exp_zero.push_back(8'h00);
    exp_zero2 = {exp_zero, exp_zero};

    up_if.vec_in   = '0;
    up_if.valid_in = 1'b0;
    rst_in         = 1'b0;

    // Reset asserted before any clock edge: outputs must settle at once.
    #2 rst_in = 1'b1;
    #1;
    chk("rst_txd",    32'(uart_txd_out),    32'd1);
    chk("rst_ready",  32'(up_if.ready_out), 32'd1);
    chk("rst_busy",   32'(busy_out),        32'd0);
    chk("rst_frames", 32'(frames_sent_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // Single frame.
    byte_q.delete(); start_q.delete();
    send_one(V1, 1'b0, acc);
    chk("single_txd_low",  32'(uart_txd_out),    32'd0);
    chk("single_busy",     32'(busy_out),        32'd1);
    chk("single_notready", 32'(up_if.ready_out), 32'd0);
    wait_idle("single_idle", drop);
    check_bytes("single", exp_v1);
    if (start_q.size() > 0) begin
      chk("single_latency", 32'(start_q[0] - acc), 32'd1);
      // 560 bit cycles plus the DONE cycle before busy drops.
      chk("single_length", 32'(drop - start_q[0]), 32'(14 * BYTE_CYC + 1));
    end
    chk("single_frames", 32'(frames_sent_out), 32'd1);
    chk("single_ready",  32'(up_if.ready_out), 32'd1);

    // Input stability: vec_in scrambled right after acceptance.
    byte_q.delete(); start_q.delete();
    send_one(V1, 1'b1, acc);
    wait_idle("stable_idle", drop);
    check_bytes("stable", exp_v1);
    chk("stable_frames", 32'(frames_sent_out), 32'd2);

    // valid_in pulsed while busy is ignored.
    byte_q.delete(); start_q.delete();
    send_one(V1, 1'b0, acc);
    repeat (100) @(negedge clk_in);
    chk("ignore_notready", 32'(up_if.ready_out), 32'd0);
    up_if.valid_in = 1'b1;
    @(negedge clk_in);
    up_if.valid_in = 1'b0;
    wait_idle("ignore_idle", drop);
    repeat (60) @(negedge clk_in);
    chk("ignore_starts", 32'(start_q.size()), 32'd14);
    check_bytes("ignore", exp_v1);
    chk("ignore_frames", 32'(frames_sent_out), 32'd3);

    // Back-to-back frames with valid_in held high.
    byte_q.delete(); start_q.delete();
    up_if.vec_in   = '0;
    up_if.valid_in = 1'b1;
    accepts = 0;
    n = 0;
    while (accepts < 2 && n < 3000) begin
      if (up_if.ready_out === 1'b1) accepts++;
      @(negedge clk_in);
      n++;
    end
    up_if.valid_in = 1'b0;
    chk("b2b_accepts", 32'(accepts), 32'd2);
    wait_idle("b2b_idle", drop);
    check_bytes("b2b", exp_zero2);
    if (start_q.size() >= 15)
      chk("b2b_gap", 32'(start_q[14] - start_q[13]), 32'(BYTE_CYC + 2));
    chk("b2b_frames", 32'(frames_sent_out), 32'd5);

    // Reset during payload byte 5 (frame byte 6).
    byte_q.delete(); start_q.delete();
    send_one(V1, 1'b0, acc);
    n = 0;
    while (byte_q.size() < 6 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    chk("midrst_reached", 32'(byte_q.size()), 32'd6);
    repeat (10) @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    chk("midrst_txd",    32'(uart_txd_out),    32'd1);
    chk("midrst_busy",   32'(busy_out),        32'd0);
    chk("midrst_ready",  32'(up_if.ready_out), 32'd1);
    chk("midrst_frames", 32'(frames_sent_out), 32'd0);
    nstarts = start_q.size();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (60) @(negedge clk_in);
    chk("midrst_no_start", 32'(start_q.size()), 32'(nstarts));
    chk("midrst_line",     32'(uart_txd_out),   32'd1);
    byte_q.delete(); start_q.delete();
    bad_fmt = 0;
    send_one('0, 1'b0, acc);
    wait_idle("after_rst_idle", drop);
    check_bytes("after_rst", exp_zero);
    chk("after_rst_frames", 32'(frames_sent_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
